// File: rtl/nasti_stream_pkg.sv
// Shared types and helpers for the NASTI-stream blocks.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package nasti_stream_pkg;

    localparam int NS_N_PORT     = 4;
    localparam int NS_DATA_WIDTH = 64;
    localparam int NS_ID_WIDTH   = 4;
    localparam int NS_DEST_WIDTH = 4;
    localparam int NS_USER_WIDTH = 4;
    localparam int NS_CNT_WIDTH  = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Index width for n items, never below one bit so single-port builds still elaborate.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nasti_stream_slice.sv
// Two-entry skid register for a flat stream payload; outputs driven straight from flops.
// Latency: 1 cycle input to output, 1 beat/cycle sustained while the sink is ready.
// Backpressure: o_rdy is registered (count<2), so no combinational path from i_rdy to o_rdy.
module nasti_stream_slice #(
    parameter int PL_W = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_vld,
    output logic            o_rdy,
    input  logic [PL_W-1:0] i_dat,
    output logic            o_vld,
    input  logic            i_rdy,
    output logic [PL_W-1:0] o_dat
);

    logic [1:0]      r_cnt;
    logic [1:0]      w_cnt_nxt;
    logic            r_vld;
    logic            r_rdy;
    logic [PL_W-1:0] r_ent0;
    logic [PL_W-1:0] r_ent1;
    logic            w_push;
    logic            w_pop;

    assign w_push = i_vld && r_rdy;
    assign w_pop  = r_vld && i_rdy;
    assign o_rdy  = r_rdy;
    assign o_vld  = r_vld;
    assign o_dat  = r_ent0;

    // Occupancy update; push together with pop leaves the count unchanged.
    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + 2'd1;
            2'b01:   w_cnt_nxt = r_cnt - 2'd1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Entry 0 is always the head; entry 1 only holds the beat absorbed while the sink stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= 2'd0;
            r_vld  <= 1'b0;
            r_rdy  <= 1'b1;
            r_ent0 <= '0;
            r_ent1 <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_vld <= (w_cnt_nxt != 2'd0);
            r_rdy <= (w_cnt_nxt != 2'd2);
            if (w_push && ((r_cnt == 2'd0) || w_pop)) begin
                r_ent0 <= i_dat;
            end else if (w_pop) begin
                r_ent0 <= (r_cnt == 2'd2) ? r_ent1 : '0;
            end
            if (w_push && !w_pop && (r_cnt == 2'd1)) begin
                r_ent1 <= i_dat;
            end
        end
    end

endmodule

// File: rtl/nasti_stream_arb_mux.sv
// N-to-1 stream packet mux: arbitrates ports addressed to DEST_ID, holds grant until t_last.
// Latency: one arbitration bubble per packet, then 1 cycle through the output skid slice.
// Backpressure: only the granted port sees in_ready, taken from the slice's registered ready.
module nasti_stream_arb_mux
    import nasti_stream_pkg::*;
#(
    parameter int N_PORT     = NS_N_PORT,
    parameter int DATA_WIDTH = NS_DATA_WIDTH,
    parameter int ID_WIDTH   = NS_ID_WIDTH,
    parameter int DEST_WIDTH = NS_DEST_WIDTH,
    parameter int USER_WIDTH = NS_USER_WIDTH,
    parameter int DEST_ID    = 0,
    parameter int RR_EN      = 1,
    parameter int CNT_WIDTH  = NS_CNT_WIDTH
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [N_PORT-1:0]              in_valid,
    output logic [N_PORT-1:0]              in_ready,
    input  logic [N_PORT*DATA_WIDTH-1:0]   in_data,
    input  logic [N_PORT*DATA_WIDTH/8-1:0] in_strb,
    input  logic [N_PORT*DATA_WIDTH/8-1:0] in_keep,
    input  logic [N_PORT-1:0]              in_last,
    input  logic [N_PORT*ID_WIDTH-1:0]     in_id,
    input  logic [N_PORT*DEST_WIDTH-1:0]   in_dest,
    input  logic [N_PORT*USER_WIDTH-1:0]   in_user,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [DATA_WIDTH/8-1:0]        out_strb,
    output logic [DATA_WIDTH/8-1:0]        out_keep,
    output logic                           out_last,
    output logic [ID_WIDTH-1:0]            out_id,
    output logic [DEST_WIDTH-1:0]          out_dest,
    output logic [USER_WIDTH-1:0]          out_user,
    output logic [N_PORT-1:0]              grant,
    output logic [CNT_WIDTH-1:0]           pkt_cnt
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int IDX_W    = clog2_min1(N_PORT);
    localparam int LAST_POS = ID_WIDTH + DEST_WIDTH + USER_WIDTH;
    localparam int PL_W     = DATA_WIDTH + 2 * STRB_W + 1 + LAST_POS;
    localparam logic [DEST_WIDTH-1:0] DEST_MATCH = DEST_WIDTH'(DEST_ID);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [N_PORT-1:0] r_grant;
    logic [N_PORT-1:0] w_grant_nxt;
    logic [IDX_W-1:0]  r_gidx;
    logic [IDX_W-1:0]  w_gidx_nxt;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  w_ptr_nxt;
    logic [IDX_W-1:0]  w_base;
    logic [N_PORT-1:0] w_req;
    logic [N_PORT-1:0] w_req_hi;
    logic [N_PORT-1:0] w_pick;
    logic              w_win_vld;
    logic [IDX_W-1:0]  w_win_idx;
    logic [N_PORT-1:0] w_win_oh;
    logic              w_sel_vld;
    logic [PL_W-1:0]   w_sel_pl;
    logic              w_sel_last;
    logic              w_busy;
    logic              w_slice_rdy;
    logic              w_acc;
    logic [PL_W-1:0]   w_out_pl;
    logic [CNT_WIDTH-1:0] r_pkt_cnt;

    assign w_busy = (r_state == ST_BUSY);
    assign w_base = (RR_EN != 0) ? r_ptr : '0;

    // A port requests only when its current beat is addressed to this mux.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < N_PORT; i++) begin
            w_req[i] = in_valid[i] && (in_dest[i*DEST_WIDTH +: DEST_WIDTH] == DEST_MATCH);
        end
    end

    // Winner = lowest requester at or above the base, else lowest overall (wrap-around).
    always_comb begin
        w_req_hi = '0;
        for (int i = 0; i < N_PORT; i++) begin
            w_req_hi[i] = w_req[i] && (i >= int'(w_base));
        end
        w_pick    = (|w_req_hi) ? w_req_hi : w_req;
        w_win_vld = |w_req;
        w_win_idx = '0;
        w_win_oh  = '0;
        for (int i = N_PORT - 1; i >= 0; i--) begin
            if (w_pick[i]) begin
                w_win_idx   = IDX_W'(i);
                w_win_oh    = '0;
                w_win_oh[i] = 1'b1;
            end
        end
    end

    // Route the granted port's handshake and payload towards the slice.
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_pl  = '0;
        for (int i = 0; i < N_PORT; i++) begin
            if (r_grant[i]) begin
                w_sel_vld = in_valid[i];
                w_sel_pl  = {in_data[i*DATA_WIDTH +: DATA_WIDTH],
                             in_strb[i*STRB_W +: STRB_W],
                             in_keep[i*STRB_W +: STRB_W],
                             in_last[i],
                             in_id[i*ID_WIDTH +: ID_WIDTH],
                             in_dest[i*DEST_WIDTH +: DEST_WIDTH],
                             in_user[i*USER_WIDTH +: USER_WIDTH]};
            end
        end
    end

    assign w_sel_last = w_sel_pl[LAST_POS];
    assign w_acc      = w_busy && w_sel_vld && w_slice_rdy;
    assign in_ready   = r_grant & {N_PORT{w_busy && w_slice_rdy}};
    assign grant      = r_grant;

    // Next state: grab a winner when idle, release on the accepted last beat.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_gidx_nxt  = r_gidx;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = w_win_oh;
                    w_gidx_nxt  = w_win_idx;
                end
            end
            ST_BUSY: begin
                if (w_acc && w_sel_last) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    if (RR_EN != 0) begin
                        w_ptr_nxt = (r_gidx == IDX_W'(N_PORT - 1)) ? '0 : r_gidx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_gidx  <= w_gidx_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    nasti_stream_slice #(
        .PL_W (PL_W)
    ) u_slice (
        .i_clk   (aclk),
        .i_rst_n (aresetn),
        .i_vld   (w_sel_vld && w_busy),
        .o_rdy   (w_slice_rdy),
        .i_dat   (w_sel_pl),
        .o_vld   (out_valid),
        .i_rdy   (out_ready),
        .o_dat   (w_out_pl)
    );

    assign {out_data, out_strb, out_keep, out_last, out_id, out_dest, out_user} = w_out_pl;

    // Count packets completed at the output; wraps naturally.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pkt_cnt <= '0;
        end else if (out_valid && out_ready && out_last) begin
            r_pkt_cnt <= r_pkt_cnt + 1'b1;
        end
    end

    assign pkt_cnt = r_pkt_cnt;

endmodule

// File: tb/tb_nasti_stream_arb_mux.sv
// Bench for nasti_stream_arb_mux: round-robin and fixed-priority instances side by side.
// Latency: the model predicts every cycle (grant, in_ready, out_valid, payload, pkt_cnt).
// Backpressure: out_ready is driven either steady high or in a 1,0,0,1 pattern.
module tb_nasti_stream_arb_mux;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int IW  = 4;
    localparam int DSW = 4;
    localparam int UW  = 4;
    localparam int CW  = 16;
    localparam logic [DSW-1:0] DEST = 4'd0;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [SW-1:0]  strb;
        logic [SW-1:0]  keep;
        logic           last;
        logic [IW-1:0]  id;
        logic [DSW-1:0] dest;
        logic [UW-1:0]  user;
    } beat_t;

    logic aclk;
    logic aresetn;

    logic [N-1:0]     in_valid [2];
    logic [N-1:0]     in_ready [2];
    logic [N*DW-1:0]  in_data  [2];
    logic [N*SW-1:0]  in_strb  [2];
    logic [N*SW-1:0]  in_keep  [2];
    logic [N-1:0]     in_last  [2];
    logic [N*IW-1:0]  in_id    [2];
    logic [N*DSW-1:0] in_dest  [2];
    logic [N*UW-1:0]  in_user  [2];
    logic             out_valid[2];
    logic             out_ready[2];
    logic [DW-1:0]    out_data [2];
    logic [SW-1:0]    out_strb [2];
    logic [SW-1:0]    out_keep [2];
    logic             out_last [2];
    logic [IW-1:0]    out_id   [2];
    logic [DSW-1:0]   out_dest [2];
    logic [UW-1:0]    out_user [2];
    logic [N-1:0]     grant    [2];
    logic [CW-1:0]    pkt_cnt  [2];

    nasti_stream_arb_mux #(
        .N_PORT(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW),
        .DEST_ID(0), .RR_EN(1), .CNT_WIDTH(CW)
    ) dut_rr (
        .aclk(aclk), .aresetn(aresetn),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .in_strb(in_strb[0]), .in_keep(in_keep[0]), .in_last(in_last[0]),
        .in_id(in_id[0]), .in_dest(in_dest[0]), .in_user(in_user[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_strb(out_strb[0]), .out_keep(out_keep[0]), .out_last(out_last[0]),
        .out_id(out_id[0]), .out_dest(out_dest[0]), .out_user(out_user[0]),
        .grant(grant[0]), .pkt_cnt(pkt_cnt[0])
    );

    nasti_stream_arb_mux #(
        .N_PORT(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW),
        .DEST_ID(0), .RR_EN(0), .CNT_WIDTH(CW)
    ) dut_fp (
        .aclk(aclk), .aresetn(aresetn),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .in_strb(in_strb[1]), .in_keep(in_keep[1]), .in_last(in_last[1]),
        .in_id(in_id[1]), .in_dest(in_dest[1]), .in_user(in_user[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_strb(out_strb[1]), .out_keep(out_keep[1]), .out_last(out_last[1]),
        .out_id(out_id[1]), .out_dest(out_dest[1]), .out_user(out_user[1]),
        .grant(grant[1]), .pkt_cnt(pkt_cnt[1])
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Sources, model state and statistics.
    beat_t       srcq [2][N][$];
    beat_t       sb   [2][$];
    int          ord  [2][$];
    bit          m_busy [2];
    int          m_own  [2];
    int          m_ptr  [2];
    int          m_acc  [2];
    logic [CW-1:0] m_pkt [2];
    int          or_mode [2];
    int          or_cnt  [2];
    int          st_beats [2];
    int          st_bad_dest [2];
    int          st_rdy1 [2];
    int          st_full_rdy [2];
    bit          grec;
    int          gval [$];
    int          glen [$];
    int          pkt_seq;
    int          n_cmp;
    int          n_fail;

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", nm, d, act, exp, $time);
        end
    endtask

    task automatic load_pkt(input int d, input int port, input int nb, input logic [DSW-1:0] dst);
        beat_t b;
        for (int k = 0; k < nb; k++) begin
            b.data = {8'(d), 8'(port), 8'(pkt_seq), 8'(k)};
            b.strb = 4'(k) ^ 4'hA;
            b.keep = 4'hF;
            b.last = (k == nb - 1);
            b.id   = 4'(port);
            b.dest = dst;
            b.user = 4'(pkt_seq);
            srcq[d][port].push_back(b);
        end
        pkt_seq++;
    endtask

    task automatic drive();
        beat_t h;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                h = '0;
                if (srcq[d][i].size() > 0) h = srcq[d][i][0];
                in_valid[d][i]           = (srcq[d][i].size() > 0);
                in_data[d][i*DW +: DW]   = h.data;
                in_strb[d][i*SW +: SW]   = h.strb;
                in_keep[d][i*SW +: SW]   = h.keep;
                in_last[d][i]            = h.last;
                in_id[d][i*IW +: IW]     = h.id;
                in_dest[d][i*DSW +: DSW] = h.dest;
                in_user[d][i*UW +: UW]   = h.user;
            end
            if (or_mode[d] == 0) out_ready[d] = 1'b1;
            else out_ready[d] = ((or_cnt[d] % 4) == 0) || ((or_cnt[d] % 4) == 3);
            or_cnt[d]++;
        end
    endtask

    // Compare the DUT against the model, then advance the model across the coming edge.
    task automatic step(input int d);
        logic [N-1:0] er, eg;
        beat_t ob, hb;
        bit pop, fnd;
        int base, o;
        er = '0;
        eg = '0;
        if (m_busy[d]) begin
            eg[m_own[d]] = 1'b1;
            if (sb[d].size() < 2) er[m_own[d]] = 1'b1;
        end
        chk("grant", d, grant[d], eg);
        chk("in_ready", d, in_ready[d], er);
        chk("out_valid", d, out_valid[d], sb[d].size() > 0);
        chk("pkt_cnt", d, pkt_cnt[d], m_pkt[d]);
        if (sb[d].size() > 0) begin
            ob = {out_data[d], out_strb[d], out_keep[d], out_last[d], out_id[d], out_dest[d], out_user[d]};
            chk("payload", d, ob, sb[d][0]);
        end
        if (out_valid[d] && out_ready[d]) st_beats[d]++;
        if (out_valid[d] && out_ready[d] && out_dest[d] != DEST) st_bad_dest[d]++;
        if (in_ready[d][1]) st_rdy1[d]++;
        if (sb[d].size() == 2 && in_ready[d] != '0) st_full_rdy[d]++;
        if (grec && d == 0) begin
            if (gval.size() == 0 || gval[gval.size()-1] != int'(grant[0])) begin
                gval.push_back(int'(grant[0]));
                glen.push_back(1);
            end else begin
                glen[glen.size()-1]++;
            end
        end

        pop = (sb[d].size() > 0) && out_ready[d];
        if (m_busy[d]) begin
            o = m_own[d];
            if (srcq[d][o].size() > 0 && er[o]) begin
                hb = srcq[d][o].pop_front();
                sb[d].push_back(hb);
                m_acc[d]++;
                if (hb.last) begin
                    m_busy[d] = 1'b0;
                    if (d == 0) m_ptr[d] = (o + 1) % N;
                end
            end
        end else begin
            fnd  = 1'b0;
            base = (d == 0) ? m_ptr[d] : 0;
            for (int k = 0; k < N; k++) begin
                int p;
                p = (base + k) % N;
                if (!fnd && srcq[d][p].size() > 0) begin
                    hb = srcq[d][p][0];
                    if (hb.dest == DEST) begin
                        fnd       = 1'b1;
                        m_busy[d] = 1'b1;
                        m_own[d]  = p;
                    end
                end
            end
        end
        if (pop) begin
            ob = sb[d].pop_front();
            if (ob.last) begin
                m_pkt[d] = m_pkt[d] + 1'b1;
                ord[d].push_back(int'(ob.id));
            end
        end
    endtask

    task automatic cycle();
        @(negedge aclk);
        drive();
        #1;
        step(0);
        step(1);
    endtask

    function automatic bit idle_done(input int d);
        beat_t h;
        if (m_busy[d] || sb[d].size() != 0) return 1'b0;
        for (int i = 0; i < N; i++) begin
            if (srcq[d][i].size() > 0) begin
                h = srcq[d][i][0];
                if (h.dest == DEST) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    task automatic drain(input int d, input int maxc, input string nm);
        int n;
        n = 0;
        while (!idle_done(d) && n < maxc) begin
            cycle();
            n++;
        end
        if (!idle_done(d)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s timeout: still busy after %0d cycles, required drained", nm, maxc);
        end
        cycle();
    endtask

    task automatic clr_stats();
        for (int d = 0; d < 2; d++) begin
            st_beats[d] = 0; st_bad_dest[d] = 0; st_rdy1[d] = 0; st_full_rdy[d] = 0;
            ord[d].delete();
        end
    endtask

    task automatic chk_ord(input string nm, input int d, input int exp[$]);
        chk({nm, "_len"}, d, ord[d].size(), exp.size());
        for (int i = 0; i < exp.size() && i < ord[d].size(); i++) chk(nm, d, ord[d][i], exp[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a0;
        n_cmp = 0; n_fail = 0; pkt_seq = 1; grec = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b0; m_own[d] = 0; m_ptr[d] = 0; m_acc[d] = 0; m_pkt[d] = '0;
            or_mode[d] = 0; or_cnt[d] = 0;
        end
        clr_stats();
        aresetn = 1'b0;
        drive();
        repeat (2) @(posedge aclk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_valid", d, out_valid[d], 0);
            chk("rst_in_ready", d, in_ready[d], 0);
            chk("rst_grant", d, grant[d], 0);
            chk("rst_pkt_cnt", d, pkt_cnt[d], 0);
            chk("rst_out_data", d, out_data[d], 0);
        end
        @(negedge aclk);
        aresetn = 1'b1;

        // Round-robin over ports 0,1,2, then 0 and 1 re-request.
        load_pkt(0, 0, 2, DEST); load_pkt(0, 1, 2, DEST); load_pkt(0, 2, 2, DEST);
        drain(0, 100, "t1a");
        chk("t1_pkt_cnt3", 0, pkt_cnt[0], 3);
        load_pkt(0, 0, 2, DEST); load_pkt(0, 1, 2, DEST);
        drain(0, 100, "t1b");
        chk_ord("t1_order", 0, '{0, 1, 2, 0, 1});
        chk("t1_pkt_cnt5", 0, pkt_cnt[0], 5);

        // Non-matching dest on port 1 is never served.
        clr_stats();
        load_pkt(0, 1, 2, 4'd3); load_pkt(0, 2, 2, DEST);
        drain(0, 100, "t2");
        chk_ord("t2_order", 0, '{2});
        chk("t2_rdy1_cnt", 0, st_rdy1[0], 0);
        chk("t2_bad_dest", 0, st_bad_dest[0], 0);
        chk("t2_beats", 0, st_beats[0], 2);
        srcq[0][1].delete();

        // Long packet under a stalling sink.
        clr_stats();
        or_mode[0] = 1; or_cnt[0] = 0;
        load_pkt(0, 0, 8, DEST);
        drain(0, 200, "t3");
        or_mode[0] = 0;
        chk("t3_beats", 0, st_beats[0], 8);
        chk("t3_full_rdy", 0, st_full_rdy[0], 0);
        chk_ord("t3_order", 0, '{0});

        // Fixed priority: port 0 keeps winning while port 3 waits.
        clr_stats();
        load_pkt(1, 0, 1, DEST); load_pkt(1, 0, 1, DEST); load_pkt(1, 0, 1, DEST);
        load_pkt(1, 3, 1, DEST);
        drain(1, 100, "t4");
        chk_ord("t4_order", 1, '{0, 0, 0, 3});

        // Grant hand-over with one idle cycle; pointer advances past port 1.
        clr_stats();
        load_pkt(0, 3, 1, DEST);
        drain(0, 50, "t5a");
        gval.delete(); glen.delete();
        grec = 1'b1;
        load_pkt(0, 0, 2, DEST); load_pkt(0, 1, 2, DEST);
        drain(0, 100, "t5b");
        grec = 1'b0;
        chk("t5_gseq_len", 0, gval.size(), 5);
        if (gval.size() == 5) begin
            chk("t5_g1", 0, gval[1], 1);
            chk("t5_g1_len", 0, glen[1], 2);
            chk("t5_g2", 0, gval[2], 0);
            chk("t5_idle_len", 0, glen[2], 1);
            chk("t5_g3", 0, gval[3], 2);
        end
        load_pkt(0, 0, 1, DEST); load_pkt(0, 2, 1, DEST);
        drain(0, 50, "t5c");
        chk_ord("t5_order", 0, '{3, 0, 1, 2, 0});

        // Reset in the middle of a 5-beat packet.
        clr_stats();
        a0 = m_acc[0];
        load_pkt(0, 0, 5, DEST);
        n = 0;
        while (m_acc[0] < a0 + 2 && n < 50) begin
            cycle();
            n++;
        end
        if (m_acc[0] < a0 + 2) begin
            n_cmp++; n_fail++;
            $display("FAIL t6_wait timeout: beats not accepted, required 2");
        end
        chk("t6_pre_valid", 0, out_valid[0], 1);
        chk("t6_pre_grant", 0, grant[0], 4'b0001);
        #2 aresetn = 1'b0;
        #1;
        chk("t6_rst_valid", 0, out_valid[0], 0);
        chk("t6_rst_ready", 0, in_ready[0], 0);
        chk("t6_rst_grant", 0, grant[0], 0);
        chk("t6_rst_pkt", 0, pkt_cnt[0], 0);
        for (int d = 0; d < 2; d++) begin
            sb[d].delete();
            for (int i = 0; i < N; i++) srcq[d][i].delete();
            m_busy[d] = 1'b0; m_ptr[d] = 0; m_pkt[d] = '0;
        end
        drive();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        load_pkt(0, 2, 1, DEST);
        drain(0, 50, "t6b");
        chk_ord("t6_order", 0, '{2});
        chk("t6_pkt_cnt", 0, pkt_cnt[0], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/nasti_stream_arb_mux.md
Name: nasti_stream_arb_mux

Overview:
- N-to-1 NASTI-stream packet multiplexer.
- Only input ports whose t_dest equals DEST_ID are eligible.
- Selection is round-robin (or fixed priority), and a packet holds the grant until its t_last beat.
- Output passes through a 2-entry skid slice, so throughput is one beat per cycle with fully registered outputs.
- Sits between several DMA/stream producers and one stream consumer.
- Provides grant and packet-count status for debug.

Parameters:
- N_PORT, 4: number of input ports (>=1).
- DATA_WIDTH, 64: t_data width. Must be a multiple of 8.
- ID_WIDTH, 4: t_id width.
- DEST_WIDTH, 4: t_dest width.
- USER_WIDTH, 4: t_user width.
- DEST_ID, 0: t_dest value this mux accepts.
- RR_EN, 1: arbitration mode. 1 = round-robin, 0 = fixed priority (lowest index wins).
- CNT_WIDTH, 16: packet counter width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset. Asynchronous assert, active-low.
- in_valid  in  N_PORT  per-port t_valid.
- in_ready  out  N_PORT  per-port t_ready.
- in_data  in  N_PORT*DATA_WIDTH  t_data. Port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]; all bundled inputs below pack the same way.
- in_strb  in  N_PORT*DATA_WIDTH/8  t_strb.
- in_keep  in  N_PORT*DATA_WIDTH/8  t_keep.
- in_last  in  N_PORT  t_last.
- in_id  in  N_PORT*ID_WIDTH  t_id.
- in_dest  in  N_PORT*DEST_WIDTH  t_dest.
- in_user  in  N_PORT*USER_WIDTH  t_user.
- out_valid  out  1  output t_valid.
- out_ready  in  1  output t_ready.
- out_data, out_strb, out_keep, out_last, out_id, out_dest, out_user  out  single-port widths as above  output payload.
- grant  out  N_PORT  one-hot of the port currently owning the output. 0 when idle.
- pkt_cnt  out  CNT_WIDTH  number of packets completed at the output.

Behaviour:
- Reset:
  - FSM=IDLE, grant=0, rr pointer=0, slice empty.
  - out_valid=0, in_ready=0, pkt_cnt=0.
  - Payload outputs are don't-care while out_valid=0; implementation drives them to 0.
- Request: req[i] = in_valid[i] && in_dest[i]==DEST_ID. Ports with a non-matching dest are never granted and never see in_ready.
- FSM IDLE:
  - If any req, select a winner and register grant[winner]=1, then go BUSY.
  - Round-robin: the first requesting index at or after the rr pointer, wrapping modulo N_PORT.
  - Fixed priority: the lowest requesting index.
  - in_ready is 0 in IDLE. This costs one arbitration bubble cycle per packet.
- FSM BUSY:
  - in_ready[g] = slice_in_ready. All other ports have in_ready=0.
  - A beat is accepted when in_valid[g] && in_ready[g]. It is written into the slice unchanged, including t_dest.
  - When the accepted beat has in_last=1: next cycle FSM=IDLE, grant=0, rr pointer = (g+1) mod N_PORT. The pointer is unchanged when RR_EN=0.
  - Once in BUSY, a dest change on the granted port mid-packet is ignored; the grant holds until last.
- Skid slice:
  - Two entries. slice_in_ready = (count<2), registered.
  - out_valid = (count>0), and out_* are driven from registers.
  - Latency input to output is 1 cycle.
  - Sustains 1 beat/cycle while out_ready=1.
  - Absorbs one extra beat when out_ready falls, with no combinational out_ready->in_ready path.
  - Simultaneous push and pop at count=2 is impossible (ready is 0); at count=1 or count=0 with pop, count is unchanged.
- pkt_cnt:
  - Increments when out_valid && out_ready && out_last.
  - Wraps at 2^CNT_WIDTH.
- Single-beat packet: IDLE -> BUSY -> IDLE. 2 cycles per packet minimum.
- N_PORT=1: pointer logic degenerates and the port index width is clamped to 1 bit. Behaviour is otherwise identical.
- Reset mid-packet: all state is cleared immediately and the slice contents are discarded. The truncated packet is not completed; the source is responsible for recovery.
- Output order always equals acceptance order. Beats from different ports never interleave.

Decomposition:
- nasti_stream_pkg: DEST_ID-independent helpers.
  - Function clog2_min1(n).
  - Typedef for the FSM state enum {IDLE, BUSY}.
  - Default width constants.
- Sub-module nasti_stream_slice: 2-entry skid register.
  - Parameterised by the total payload width.
  - The payload is concatenated {data,strb,keep,last,id,dest,user}.
  - Reusable by other stream blocks.

Test Plan:
- Ports 0,1,2 each hold a 2-beat packet, dest=0, out_ready=1, RR_EN=1 -> output packet order 0,1,2, then 0 again if re-requested. Each packet starts 1 bubble after the previous last. pkt_cnt=3.
- Port 1 dest=3, port 2 dest=0 -> only port 2 is granted. in_ready[1] stays 0 throughout. Output t_dest=0.
- 8-beat packet on port 0 with out_ready toggled 1,0,0,1 repeating -> all 8 beats arrive in order with no loss or duplication. in_ready never 1 when the slice is full.
- RR_EN=0, ports 0 and 3 request continuously -> only port 0 is served. Port 3 never granted.
- Ports 0 and 1 request; port 0 sends last while port 1 is still valid -> IDLE for 1 cycle, then grant=4'b0010. rr pointer becomes 2 after port 1's last.
- aresetn low during beat 3 of 5 -> out_valid=0, in_ready=0, grant=0, pkt_cnt=0 asynchronously. After release, a new packet passes normally.
